// File: rtl/rx_controller.sv
// rx_controller: receive sequencer, parity/stop check into a FIFO; RX_CONTROLLER_IRQ_EN builds irq_o
module rx_controller #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cr_re_i,
  input  logic        cr_ds_i,
  input  logic [1:0]  cr_p_i,
  input  logic        cr_s_i,
  input  logic [10:0] packet_i,
  input  logic        packet_valid_i,
  input  logic        rxdr_read_i,
  input  logic        ore_clr_i,
  input  logic        flush_i,
  output logic [7:0]  rxdr_o,
  output logic        sr_rxne_o,
  output logic        sr_pe_o,
  output logic        sr_fe_o,
  output logic        sr_ore_o,
  output logic        irq_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, CHECK, STORE} state_t;
  state_t state, state_nxt;
  logic [10:0] pkt;
  logic ds, s;
  logic [1:0] p;
  logic [AW:0] wp, rp;
  logic [9:0] mem [FIFO_DEPTH];
  logic [9:0] head;
  logic ore, empty, full, pop, push, pe, fe, ore_set;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? ((packet_valid_i & cr_re_i) ? CHECK : IDLE) :
                state == CHECK ? STORE : IDLE;
  always_comb begin
    empty = wp == rp;
    full = (wp[AW] != rp[AW]) & (wp[AW-1:0] == rp[AW-1:0]);
    pop = rxdr_read_i & ~empty;
    pe = p[1] & (^pkt[6:0] ^ (~ds & pkt[7]) ^ pkt[8] ^ p[0]);
    fe = ~pkt[9] | (s & ~pkt[10]);
    push = (state == STORE) & (~full | pop);
    ore_set = ((state == STORE) & full & ~pop) | (packet_valid_i & cr_re_i & (state != IDLE));
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      pkt <= '0;
      ds <= 1'b0;
      p <= '0;
      s <= 1'b0;
    end else if (state == IDLE && packet_valid_i && cr_re_i) begin
      pkt <= packet_i;
      ds <= cr_ds_i;
      p <= cr_p_i;
      s <= cr_s_i;
    end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wp <= '0;
      rp <= '0;
      ore <= 1'b0;
    end else begin
      wp <= flush_i ? '0 : wp + {{AW{1'b0}}, push};
      rp <= flush_i ? '0 : rp + {{AW{1'b0}}, pop};
      ore <= ore_set | (ore & ~ore_clr_i);
    end
  always_ff @(posedge clk_i)
    if (push && !flush_i) mem[wp[AW-1:0]] <= {fe, pe, pkt[7:0]};
  assign head = empty ? 10'd0 : mem[rp[AW-1:0]];
  assign rxdr_o = head[7:0];
  assign sr_pe_o = head[8];
  assign sr_fe_o = head[9];
  assign sr_rxne_o = ~empty;
  assign sr_ore_o = ore;
`ifdef RX_CONTROLLER_IRQ_EN
  logic irq;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) irq <= 1'b0;
    else irq <= sr_rxne_o | sr_ore_o | sr_pe_o | sr_fe_o;
  assign irq_o = irq;
`else
  assign irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_rx_controller.sv
// tb_rx_controller: queue-based receive model checked every cycle plus directed literal checks
module tb_rx_controller;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic re = 1'b1, ds = 1'b0, s = 1'b0;
  logic [1:0] p = 2'b10;
  logic [10:0] packet = '0;
  logic valid = 1'b0, rd = 1'b0, ore_clr = 1'b0, flush = 1'b0;
  logic [7:0] rxdr;
  logic rxne, pe, fe, ore, irq;
  int total = 0;
  int passed = 0;
  logic [9:0] mq[$];
  logic [9:0] pend;
  int busy, b0;
  bit set_ev;
  logic m_ore, m_irq;
  logic [9:0] m_head;
  localparam logic [10:0] PKT_A5 = 11'b010_1010_0101;
  rx_controller #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cr_re_i(re), .cr_ds_i(ds), .cr_p_i(p), .cr_s_i(s),
    .packet_i(packet), .packet_valid_i(valid), .rxdr_read_i(rd), .ore_clr_i(ore_clr),
    .flush_i(flush), .rxdr_o(rxdr), .sr_rxne_o(rxne), .sr_pe_o(pe), .sr_fe_o(fe),
    .sr_ore_o(ore), .irq_o(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  function automatic logic [9:0] entry(input logic [10:0] pk);
    int n;
    bit e_pe, e_fe;
    n = ds ? $countones(pk[6:0]) : $countones(pk[7:0]);
    n += int'(pk[8]);
    e_pe = p[1] && ((n % 2) != int'(p[0]));
    e_fe = !pk[9] || (s && !pk[10]);
    return {e_fe, e_pe, pk[7:0]};
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mq.delete();
      busy = 0;
      m_ore = 1'b0;
      m_irq = 1'b0;
    end else begin
`ifdef RX_CONTROLLER_IRQ_EN
      m_irq = (mq.size() > 0) || m_ore || (mq.size() > 0 && (mq[0][9] || mq[0][8]));
`else
      m_irq = 1'b0;
`endif
      set_ev = 0;
      b0 = busy;
      if (rd && mq.size() > 0) void'(mq.pop_front());
      if (b0 == 1) begin
        if (mq.size() < DEPTH) mq.push_back(pend);
        else set_ev = 1;
      end
      if (flush) mq.delete();
      if (b0 > 0) busy = b0 - 1;
      if (valid && re) begin
        if (b0 == 0) begin
          pend = entry(packet);
          busy = 2;
        end else set_ev = 1;
      end
      m_ore = set_ev ? 1'b1 : (ore_clr ? 1'b0 : m_ore);
    end
  always @(negedge clk)
    if (rst_n) begin
      m_head = mq.size() > 0 ? mq[0] : 10'd0;
      chk("rxne", 32'(rxne), 32'(mq.size() > 0));
      chk("rxdr", 32'(rxdr), 32'(m_head[7:0]));
      chk("pe", 32'(pe), 32'(m_head[8]));
      chk("fe", 32'(fe), 32'(m_head[9]));
      chk("ore", 32'(ore), 32'(m_ore));
      chk("irq", 32'(irq), 32'(m_irq));
    end
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [10:0] pk);
    packet = pk;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask
  task automatic pop_one();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask
  task automatic pulse_clr();
    ore_clr = 1'b1;
    @(negedge clk);
    ore_clr = 1'b0;
  endtask
  initial begin
    idle(3);
    chk("reset_outputs", {rxdr, rxne, pe, fe, ore, irq}, 32'd0);
    rst_n = 1'b1;
    idle(1);
    send(PKT_A5);
    chk("t1_rxne_n1", 32'(rxne), 32'd0);
    idle(1);
    chk("t1_rxne_n2", 32'(rxne), 32'd0);
    idle(1);
    chk("t1_rxne_n3", 32'(rxne), 32'd1);
    chk("t1_rxdr", 32'(rxdr), 32'h0A5);
    chk("t1_pe_fe", {pe, fe}, 32'd0);
    pop_one();
    chk("t1_pop_rxne", 32'(rxne), 32'd0);
    p = 2'b11;
    send(PKT_A5);
    idle(2);
    chk("t2_odd_pe", {pe, fe}, 32'b10);
    s = 1'b1;
    send(PKT_A5);
    idle(2);
    pop_one();
    chk("t2_two_stop_fe", {pe, fe}, 32'b11);
    pop_one();
    p = 2'b00;
    s = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send({3'b010, 8'(i)});
      idle(2);
    end
    chk("t3_ore_full", 32'(ore), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("t3_pop_order", 32'(rxdr), 32'(i));
      pop_one();
    end
    chk("t3_empty", 32'(rxne), 32'd0);
    pulse_clr();
    chk("t3_ore_clr", 32'(ore), 32'd0);
    for (int i = 0; i < 4; i++) begin
      send({3'b010, 8'(8'h11 + i)});
      idle(2);
    end
    send({3'b010, 8'h15});
    idle(1);
    pop_one();
    chk("t4_no_ore", 32'(ore), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t4_pop_order", 32'(rxdr), 32'(8'h12 + i));
      pop_one();
    end
    chk("t4_empty", 32'(rxne), 32'd0);
    send({3'b010, 8'h21});
    send({3'b010, 8'h22});
    idle(2);
    chk("t5_ore_busy", 32'(ore), 32'd1);
    chk("t5_first_kept", 32'(rxdr), 32'h21);
    pop_one();
    chk("t5_second_dropped", 32'(rxne), 32'd0);
    pulse_clr();
    chk("t5_ore_clr", 32'(ore), 32'd0);
    send({3'b010, 8'h23});
    packet = {3'b010, 8'h24};
    valid = 1'b1;
    ore_clr = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    ore_clr = 1'b0;
    chk("t5_set_beats_clr", 32'(ore), 32'd1);
    pulse_clr();
    pop_one();
    re = 1'b0;
    send({3'b010, 8'h31});
    idle(3);
    chk("re_off_ignored", 32'(rxne), 32'd0);
    re = 1'b1;
    send({3'b010, 8'h32});
    re = 1'b0;
    idle(2);
    chk("re_off_inflight", 32'(rxdr), 32'h32);
    re = 1'b1;
    pop_one();
    for (int i = 0; i < 3; i++) begin
      send({3'b010, 8'(8'h41 + i)});
      idle(2);
    end
    chk("t6_three_held", 32'(rxne), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t6_flush", 32'(rxne), 32'd0);
    idle(3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
